regfile_writeback_queue: RTL and testbench
==========================================

# regfile_writeback_queue

Write-side front end of the 32×16-bit register file: accepts results from the ALU and load paths over valid/ready handshakes, arbitrates them round-robin into a DEPTH-entry in-order queue, and drains one entry per cycle onto the register file's single write port (write_index/write_data/write_en). It also reports pending writes for two decode-stage lookup indices and supplies the bypass data for each, so decode can forward values not yet committed.

## Interface
- DATA_W, 16, write data width; matches register width
- IDX_W, 5, register index width (32 registers)
- DEPTH, 4, queue entries; power of two, ≥2
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- alu_valid / alu_ready  in / out  1 / 1  ALU result handshake
- alu_index / alu_data  in  IDX_W / DATA_W  ALU destination and value
- mem_valid / mem_ready  in / out  1 / 1  load result handshake
- mem_index / mem_data  in  IDX_W / DATA_W  load destination and value
- write_hold  in  1  1 = do not drain this cycle (port borrowed)
- write_en  out  1  register file write enable (registered)
- write_index / write_data  out  IDX_W / DATA_W  register file write port (registered)
- q1_index, q2_index  in  IDX_W  decode lookup indices
- q1_hit, q2_hit  out  1  a write to that index is pending
- q1_data, q2_data  out  DATA_W  youngest pending value for that index; 0 when no hit
- fill  out  $clog2(DEPTH)+1  queued entries (excludes the write port register)

## Operation
- Transfer on a source occurs at a rising edge where its valid && ready are both high. A source holds index/data stable while valid && !ready.
- room = (fill < DEPTH). Pops in the same cycle are not counted.
- Arbitration: only one source valid → its ready = room. Both valid → grant the source not granted last. last_grant updates only on an actual transfer. The loser's ready = 0. At most one enqueue per cycle. Ready may depend combinationally on valid; valid must not depend on ready.
- Drain: at each edge, if fill > 0 and !write_hold, the head is popped into write_index/write_data and write_en = 1. Otherwise write_en = 0, and write_index/write_data hold their values.
- Push and pop at the same edge: fill is unchanged and order is preserved. An entry pushed into an empty queue is not popped at the same edge.
- Writes to any index, including 0, pass through unmodified. Strict FIFO order; duplicate indices are allowed, and the later write wins in the register file.
- Lookup (combinational): a candidate is any valid queue entry, or the write port register when write_en = 1. Hit if any candidate index equals qN_index. The data comes from the youngest match: the newest queue entry first, then the write port register. Same-cycle incoming source data is not visible.
- Reset (asynchronous, any time): queue emptied, fill = 0, write_en = 0, write_index = 0, write_data = 0, last_grant = mem (so the ALU wins the first tie). In-flight entries are discarded. qN_hit = 0 and qN_data = 0 while in reset.

## Timing
- Latency: accepted at edge E into an empty queue with write_hold low → write_en high during the cycle after E+1. The register file captures it at edge E+2.
- Throughput: 1 write per cycle sustained. With both sources valid continuously, grants alternate ALU, mem, ALU, …
- Full: with fill = DEPTH, alu_ready = mem_ready = 0 in that cycle, even if a pop occurs at the same edge.
- write_hold sampled at edge: high → no pop, and write_en = 0 in the following cycle.
- hit/data outputs change only with state or qN_index; there is no path from alu/mem inputs to them.

## Test plan
- Reset mid-stream: fill = 3, reset_n low → write_en, write_index, write_data, and fill are 0 immediately. After release, only new pushes are written.
- Single ALU push idx 7 data 0x1234 at edge E → write_en = 1, write_index = 7, write_data = 0x1234 during cycle E+1..E+2. fill is 1 then 0.
- Both valid for 4 cycles after reset (ALU idx 1–4 with 0xA00n, mem idx 9–12 with 0xB00n) → accept order ALU1, mem9, ALU2, mem10. The write port emits in that order. The losers' ready is 0 on their losing cycles.
- write_hold = 1 with 5 pushes attempted → fill reaches 4, both readies go 0, and the 5th is not accepted. Release hold → 4 writes on consecutive cycles, in order.
- Lookup: queue holds idx 3 = 0x0011 then idx 3 = 0x0022, with q1_index = 3 → q1_hit = 1, q1_data = 0x0022. With q2_index = 4 → q2_hit = 0, q2_data = 0.
- Write port register holds idx 5 (write_en = 1) with the queue empty, q1_index = 5 → q1_hit = 1, q1_data = write_data. The next cycle, with write_en = 0 → q1_hit = 0.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Round-robin ALU/load result queue draining one entry per cycle into the register file write port.
// Latency: accept at edge E, write_en high after E+1; ready drops whenever fill == DEPTH.
module regfile_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [IDX_W-1:0]         alu_index,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [IDX_W-1:0]         mem_index,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     write_hold,
  output logic                     write_en,
  output logic [IDX_W-1:0]         write_index,
  output logic [DATA_W-1:0]        write_data,
  input  logic [IDX_W-1:0]         q1_index,
  input  logic [IDX_W-1:0]         q2_index,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [DATA_W-1:0]        q1_data,
  output logic [DATA_W-1:0]        q2_data,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] dat;
  } entry_t;

  typedef enum logic {SRC_ALU, SRC_MEM} src_e;

  entry_t           queue_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  src_e             last_grant_q;

  logic   room;
  logic   alu_win;
  logic   mem_win;
  logic   alu_xfer;
  logic   mem_xfer;
  logic   push;
  logic   pop;
  entry_t push_entry;

  // Room ignores a same-edge pop so ready never depends on write_hold.
  assign room      = fill < CNT_W'(DEPTH);
  assign alu_win   = alu_valid && (!mem_valid || last_grant_q == SRC_MEM);
  assign mem_win   = mem_valid && (!alu_valid || last_grant_q == SRC_ALU);
  assign alu_ready = alu_win && room;
  assign mem_ready = mem_win && room;
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;
  assign push      = alu_xfer || mem_xfer;
  assign pop       = (fill != '0) && !write_hold;
  assign push_entry = alu_xfer ? {alu_index, alu_data} : {mem_index, mem_data};

  always_ff @(posedge clk) begin
    if (push) queue_q[tail_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      fill         <= '0;
      last_grant_q <= SRC_MEM;
      write_en     <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      fill <= fill + CNT_W'(push) - CNT_W'(pop);
      if (alu_xfer)      last_grant_q <= SRC_ALU;
      else if (mem_xfer) last_grant_q <= SRC_MEM;
      write_en <= pop;
      if (pop) begin
        write_index <= queue_q[head_q].idx;
        write_data  <= queue_q[head_q].dat;
      end
    end
  end

  logic [IDX_W-1:0]  q_idx [2];
  logic              q_hit [2];
  logic [DATA_W-1:0] q_dat [2];

  assign q_idx[0] = q1_index;
  assign q_idx[1] = q2_index;

  // Scan oldest to newest so the youngest matching entry overrides older ones.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_hit[p] = write_en && (write_index == q_idx[p]);
      q_dat[p] = write_data;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < fill) && (queue_q[head_q + PTR_W'(i)].idx == q_idx[p])) begin
          q_hit[p] = 1'b1;
          q_dat[p] = queue_q[head_q + PTR_W'(i)].dat;
        end
      end
      if (!q_hit[p]) q_dat[p] = '0;
    end
  end

  assign q1_hit  = q_hit[0];
  assign q2_hit  = q_hit[1];
  assign q1_data = q_dat[0];
  assign q2_data = q_dat[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue; write port checked against an expected-write queue.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_index, mem_index, write_index, q1_index, q2_index;
  logic [15:0] alu_data, mem_data, write_data, q1_data, q2_data;
  logic        write_hold, write_en, q1_hit, q2_hit;
  logic [2:0]  fill;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DATA_W(16), .IDX_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
    .write_hold(write_hold), .write_en(write_en), .write_index(write_index), .write_data(write_data),
    .q1_index(q1_index), .q2_index(q2_index), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data), .fill(fill)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t arb_tab [4];
  exp_t hold_tab [5];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write port monitor: every write must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && write_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got idx %0d data %h, required no write", write_index, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_idx", 32'(write_index), 32'(mon_e.idx));
        chk("wr_data", 32'(write_data), 32'(mon_e.dat));
      end
    end
  end

  initial begin
    alu_valid = 0; alu_index = 0; alu_data = 0;
    mem_valid = 0; mem_index = 0; mem_data = 0;
    write_hold = 0; q1_index = 0; q2_index = 0;
    arb_tab  = '{ {5'd1, 16'hA001}, {5'd9, 16'hB001}, {5'd2, 16'hA002}, {5'd10, 16'hB002} };
    hold_tab = '{ {5'd3, 16'h0011}, {5'd3, 16'h0022}, {5'd20, 16'hC002}, {5'd21, 16'hC003}, {5'd22, 16'hC004} };

    // Reset state
    #1 reset_n = 0;
    #2;
    chk("rst_wen", write_en, 0);
    chk("rst_widx", write_index, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_fill", fill, 0);
    chk("rst_q1_hit", q1_hit, 0);
    chk("rst_q1_data", q1_data, 0);
    step(); step();
    reset_n = 1;

    // Single ALU push: idx 7 data 0x1234
    alu_valid = 1; alu_index = 5'd7; alu_data = 16'h1234;
    #2;
    chk("t1_alu_rdy", alu_ready, 1);
    exp_q.push_back({5'd7, 16'h1234});
    step();
    alu_valid = 0; q1_index = 5'd7;
    #1;
    chk("t1_fill1", fill, 1);
    chk("t1_wen0", write_en, 0);
    chk("t1_q1_hit_queue", q1_hit, 1);
    chk("t1_q1_data_queue", q1_data, 16'h1234);
    step();
    chk("t1_wen1", write_en, 1);
    chk("t1_widx", write_index, 7);
    chk("t1_wdata", write_data, 16'h1234);
    chk("t1_fill0", fill, 0);
    chk("t1_q1_hit_port", q1_hit, 1);
    chk("t1_q1_data_port", q1_data, 16'h1234);
    step();
    chk("t1_wen_low", write_en, 0);
    chk("t1_q1_hit_gone", q1_hit, 0);
    chk("t1_q1_data_gone", q1_data, 0);

    // Fresh reset so the ALU wins the first tie
    reset_n = 0;
    #1 reset_n = 1;

    // Arbitration: both valid for 4 cycles, sources hold until accepted
    begin
      int ai = 0;
      int mi = 0;
      for (int k = 0; k < 4; k++) begin
        alu_valid = 1; alu_index = 5'(1 + ai); alu_data = 16'hA001 + 16'(ai);
        mem_valid = 1; mem_index = 5'(9 + mi); mem_data = 16'hB001 + 16'(mi);
        #1;
        exp_q.push_back(arb_tab[k]);
        if (k % 2 == 0) begin
          chk("t2_alu_win_rdy", alu_ready, 1);
          chk("t2_mem_lose_rdy", mem_ready, 0);
          ai++;
        end else begin
          chk("t2_alu_lose_rdy", alu_ready, 0);
          chk("t2_mem_win_rdy", mem_ready, 1);
          mi++;
        end
        step();
      end
    end
    alu_valid = 0; mem_valid = 0;
    step(); step();
    chk("t2_fill_drained", fill, 0);
    chk("t2_wen_idle", write_en, 0);

    // Hold: fill to DEPTH, fifth push refused
    write_hold = 1;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_index = hold_tab[i].idx; alu_data = hold_tab[i].dat;
      if (i == 4) begin
        mem_valid = 1; mem_index = 5'd23; mem_data = 16'hBEEF;
      end
      #1;
      chk("t3_alu_rdy", alu_ready, (i < 4) ? 1 : 0);
      if (i < 4) exp_q.push_back(hold_tab[i]);
      if (i == 4) begin
        chk("t3_full_mem_rdy", mem_ready, 0);
        chk("t3_fill4", fill, 4);
      end
      step();
    end
    chk("t3_fill_still4", fill, 4);
    chk("t3_wen_held", write_en, 0);
    q1_index = 5'd3; q2_index = 5'd4;
    #1;
    chk("t3_q1_hit_dup", q1_hit, 1);
    chk("t3_q1_data_young", q1_data, 16'h0022);
    chk("t3_q2_hit_none", q2_hit, 0);
    chk("t3_q2_data_none", q2_data, 0);
    q2_index = 5'd20;
    #1;
    chk("t3_q2_hit_20", q2_hit, 1);
    chk("t3_q2_data_20", q2_data, 16'hC002);
    write_hold = 0;
    #1;
    chk("t3_full_pop_alu_rdy", alu_ready, 0);
    chk("t3_full_pop_mem_rdy", mem_ready, 0);
    step();
    alu_valid = 0; mem_valid = 0;
    for (int j = 0; j < 4; j++) begin
      chk("t3_drain_wen", write_en, 1);
      step();
    end
    chk("t3_drain_done_wen", write_en, 0);
    chk("t3_drain_fill", fill, 0);

    // Reset mid-stream with three entries queued
    write_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_index = 5'(15 + i); alu_data = 16'h0F00 + 16'(i);
      step();
    end
    alu_valid = 0;
    chk("t4_fill3", fill, 3);
    q1_index = 5'd15;
    #2 reset_n = 0;
    #1;
    chk("t4_rst_wen", write_en, 0);
    chk("t4_rst_widx", write_index, 0);
    chk("t4_rst_wdata", write_data, 0);
    chk("t4_rst_fill", fill, 0);
    chk("t4_rst_q1_hit", q1_hit, 0);
    chk("t4_rst_q1_data", q1_data, 0);
    #1 reset_n = 1;
    write_hold = 0;
    step();
    alu_valid = 1; alu_index = 5'd30; alu_data = 16'h5A5A;
    #1;
    chk("t4_new_rdy", alu_ready, 1);
    exp_q.push_back({5'd30, 16'h5A5A});
    step();
    alu_valid = 0;
    step(); step(); step();
    chk("t4_fill_end", fill, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
